// File: rtl/lane_byte_scheduler_pkg.sv
// Shared constants, state encoding and helpers for the lane byte scheduler.
package lane_byte_scheduler_pkg;

   localparam int unsigned DATA_W  = 8;
   localparam int unsigned LANES   = 4;
   localparam int unsigned BURST_W = 3;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_e;

   // A zero burst length still moves one byte.
   function automatic logic [BURST_W-1:0] eff_len(input logic [BURST_W-1:0] len);
      return (len == '0) ? BURST_W'(1) : len;
   endfunction

endpackage

// File: rtl/lane_byte_scheduler_if.sv
// Lane-side and output-side handshake bundle of the lane byte scheduler.
interface lane_byte_scheduler_if;
   import lane_byte_scheduler_pkg::*;

   logic               enable;
   logic [BURST_W-1:0] burst_len;
   logic [DATA_W-1:0]  dataIn0, dataIn1, dataIn2, dataIn3;
   logic               validIn0, validIn1, validIn2, validIn3;
   logic               readyIn0, readyIn1, readyIn2, readyIn3;
   logic [DATA_W-1:0]  dataOut;
   logic               validOut;
   logic               readyOut;
   logic [1:0]         selector;
   logic               busy;
   logic               burst_done;

   modport master (
      output enable, burst_len, dataIn0, dataIn1, dataIn2, dataIn3,
      output validIn0, validIn1, validIn2, validIn3, readyOut,
      input  readyIn0, readyIn1, readyIn2, readyIn3,
      input  dataOut, validOut, selector, busy, burst_done
   );

   modport slave (
      input  enable, burst_len, dataIn0, dataIn1, dataIn2, dataIn3,
      input  validIn0, validIn1, validIn2, validIn3, readyOut,
      output readyIn0, readyIn1, readyIn2, readyIn3,
      output dataOut, validOut, selector, busy, burst_done
   );

endinterface

// File: rtl/lane_byte_scheduler_rr_arbiter4.sv
// Combinational 4-way round-robin arbiter: first requester strictly after ptr wins.
module lane_byte_scheduler_rr_arbiter4 (
   input  logic [3:0] req,
   input  logic [1:0] ptr,
   output logic [1:0] gnt_idx,
   output logic       gnt_any
);

   always_comb begin
      gnt_idx = 2'd0;
      gnt_any = 1'b0;
      // Scan farthest-first so the nearest requester after ptr overwrites the others.
      for (int i = 4; i >= 1; i--) begin
         logic [1:0] cand;
         cand = ptr + 2'(i);
         if (req[cand]) begin
            gnt_idx = cand;
            gnt_any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/lane_byte_scheduler.sv
// Round-robin burst scheduler sharing one registered byte path among four lanes.
module lane_byte_scheduler
   import lane_byte_scheduler_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   lane_byte_scheduler_if.slave  bus
);

   logic [LANES-1:0]  lane_valid;
   logic [DATA_W-1:0] lane_data [LANES];
   logic [LANES-1:0]  ready_vec;

   state_e             state_q, state_d;
   logic [1:0]         sel_q, sel_d;
   logic [1:0]         ptr_q, ptr_d;
   logic [BURST_W-1:0] len_q, len_d;
   logic [BURST_W-1:0] cnt_q, cnt_d;
   logic [DATA_W-1:0]  data_q, data_d;
   logic               valid_q, valid_d;
   logic               done_q, done_d;

   logic [1:0] gnt_idx;
   logic       gnt_any;
   logic       slot_free;
   logic       xfer;

   assign lane_valid = {bus.validIn3, bus.validIn2, bus.validIn1, bus.validIn0};
   assign lane_data[0] = bus.dataIn0;
   assign lane_data[1] = bus.dataIn1;
   assign lane_data[2] = bus.dataIn2;
   assign lane_data[3] = bus.dataIn3;

   lane_byte_scheduler_rr_arbiter4 u_arb (
      .req     (bus.enable ? lane_valid : 4'b0000),
      .ptr     (ptr_q),
      .gnt_idx (gnt_idx),
      .gnt_any (gnt_any)
   );

   assign slot_free = !valid_q || bus.readyOut;

   // Ready depends only on registered state and downstream ready, never on validIn.
   always_comb begin
      ready_vec = '0;
      if (state_q == ST_BURST) ready_vec[sel_q] = slot_free;
   end

   assign xfer = lane_valid[sel_q] && ready_vec[sel_q];

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      valid_d = valid_q;
      done_d  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.readyOut) valid_d = 1'b0;
            if (gnt_any) begin
               sel_d   = gnt_idx;
               len_d   = eff_len(bus.burst_len);
               cnt_d   = '0;
               state_d = ST_BURST;
            end
         end
         ST_BURST: begin
            if (xfer) begin
               data_d  = lane_data[sel_q];
               valid_d = 1'b1;
               cnt_d   = cnt_q + BURST_W'(1);
               if (cnt_q + BURST_W'(1) == len_q) begin
                  state_d = ST_IDLE;
                  ptr_d   = sel_q;
                  done_d  = 1'b1;
               end
            end else if (slot_free) begin
               // Granted lane went quiet: drop the slot and end the burst short.
               valid_d = 1'b0;
               state_d = ST_IDLE;
               ptr_d   = sel_q;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         sel_q   <= 2'd0;
         ptr_q   <= 2'd3;
         len_q   <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         done_q  <= done_d;
      end
   end

   assign bus.readyIn0   = ready_vec[0];
   assign bus.readyIn1   = ready_vec[1];
   assign bus.readyIn2   = ready_vec[2];
   assign bus.readyIn3   = ready_vec[3];
   assign bus.dataOut    = data_q;
   assign bus.validOut   = valid_q;
   assign bus.selector   = sel_q;
   assign bus.busy       = (state_q == ST_BURST);
   assign bus.burst_done = done_q;

endmodule
